ysyx_25030093_ifu: RTL and testbench

//  Instruction fetch unit for the multicycle NPC core; it is the producer side of the decoder's instruction handshake.

---
 rtl/ysyx_25030093_pkg.sv | 14 +
 rtl/ysyx_25030093_ifu.sv | 80 ++++++++
 tb/tb_ysyx_25030093_ifu.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25030093_pkg.sv
// rtl/ysyx_25030093_pkg.sv - shared encodings for the NPC fetch path
package ysyx_25030093_pkg;

  typedef enum logic [1:0] {
    S_AR   = 2'b00,
    S_R    = 2'b01,
    S_HOLD = 2'b10,
    S_NPC  = 2'b11
  } ifu_state_t;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ysyx_25030093_ifu.sv
// rtl/ysyx_25030093_ifu.sv - multicycle instruction fetch over an AXI4-Lite read channel
module ysyx_25030093_ifu
  import ysyx_25030093_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  output logic [XLEN-1:0] araddr,
  output logic            arvalid,
  input  logic            arready,
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      rresp,
  input  logic            rvalid,
  output logic            rready,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault,
  input  logic            npc_valid,
  output logic            npc_ready,
  input  logic [XLEN-1:0] npc
);

  ifu_state_t      state;
  logic [XLEN-1:0] pc;
  logic            misaligned;

  // A misaligned PC never reaches the bus; it turns straight into a faulted instruction.
  assign misaligned = |pc[1:0];
  assign araddr     = pc;
  assign arvalid    = (state == S_AR) && !misaligned;
  assign rready     = (state == S_R);
  assign inst_valid = (state == S_HOLD);
  assign npc_ready  = (state == S_NPC);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_AR;
      pc         <= RESET_PC;
      inst       <= '0;
      inst_pc    <= '0;
      inst_fault <= 1'b0;
    end else begin
      case (state)
        S_AR: begin
          if (misaligned) begin
            inst       <= '0;
            inst_pc    <= pc;
            inst_fault <= 1'b1;
            state      <= S_HOLD;
          end else if (arready) begin
            state <= S_R;
          end
        end
        S_R: begin
          if (rvalid) begin
            inst       <= rdata;
            inst_pc    <= pc;
            inst_fault <= (rresp != RESP_OKAY);
            state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_ready) state <= S_NPC;
        end
        S_NPC: begin
          if (npc_valid) begin
            pc    <= npc;
            state <= S_AR;
          end
        end
        default: state <= S_AR;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25030093_ifu.sv
// tb/tb_ysyx_25030093_ifu.sv - directed self-checking bench for the fetch unit
module tb_ysyx_25030093_ifu;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0;
  logic        rready;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        npc_valid = 1'b0;
  logic        npc_ready;
  logic [31:0] npc = 32'h0;

  int n_cmp = 0;
  int n_err = 0;

  ysyx_25030093_ifu dut (
    .clock(clock), .reset(reset),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault),
    .npc_valid(npc_valid), .npc_ready(npc_ready), .npc(npc)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Address phase: arready withheld for 'delay' cycles while a stray rvalid is driven.
  task automatic do_ar(input int delay, input logic [31:0] addr);
    check("ar_valid", arvalid, 1);
    check("ar_addr", araddr, addr);
    for (int i = 0; i < delay; i++) begin
      arready = 1'b0;
      rvalid  = 1'b1;
      rdata   = 32'hbad0_0000 + i;
      tick();
      check("ar_valid_stall", arvalid, 1);
      check("ar_addr_stall", araddr, addr);
      check("ar_no_rready", rready, 0);
    end
    rvalid  = 1'b0;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check("ar_done_valid", arvalid, 0);
    check("r_rready", rready, 1);
  endtask

  task automatic do_r(input int delay, input logic [31:0] data, input logic [1:0] resp);
    for (int i = 0; i < delay; i++) begin
      rvalid = 1'b0;
      rdata  = 32'hf00d_0000 + i;
      tick();
      check("r_wait_rready", rready, 1);
      check("r_wait_ivalid", inst_valid, 0);
    end
    rvalid = 1'b1;
    rdata  = data;
    rresp  = resp;
    tick();
    rvalid = 1'b0;
    rdata  = 32'h5555_aaaa;
    rresp  = 2'b00;
    check("r_done_rready", rready, 0);
  endtask

  // Hold phase: inst_ready low for 'delay' cycles with npc_valid pulsing, then accepted.
  task automatic do_hold(input int delay, input logic [31:0] ei, input logic [31:0] ep, input logic ef);
    check("hold_valid", inst_valid, 1);
    check("hold_inst", inst, ei);
    check("hold_pc", inst_pc, ep);
    check("hold_fault", inst_fault, ef);
    check("hold_no_ar", arvalid, 0);
    for (int i = 0; i < delay; i++) begin
      inst_ready = 1'b0;
      npc_valid  = i[0];
      npc        = 32'hcafe_0000;
      tick();
      check("hold_stall_valid", inst_valid, 1);
      check("hold_stall_inst", inst, ei);
      check("hold_stall_pc", inst_pc, ep);
      check("hold_stall_npcrdy", npc_ready, 0);
    end
    npc_valid  = 1'b0;
    inst_ready = 1'b1;
    tick();
    check("npc_ready_rise", npc_ready, 1);
    check("npc_ivalid_low", inst_valid, 0);
  endtask

  task automatic do_npc(input int delay, input logic [31:0] value);
    for (int i = 0; i < delay; i++) begin
      npc_valid = 1'b0;
      tick();
      check("npc_wait_ready", npc_ready, 1);
      check("npc_wait_no_ar", arvalid, 0);
    end
    npc_valid = 1'b1;
    npc       = value;
    tick();
    npc_valid = 1'b0;
    npc       = 32'h0;
    check("npc_done_ready", npc_ready, 0);
  endtask

  initial begin
    reset = 1'b1;
    tick();
    tick();
    check("rst_arvalid", arvalid, 1);
    check("rst_araddr", araddr, 32'h8000_0000);
    check("rst_rready", rready, 0);
    check("rst_ivalid", inst_valid, 0);
    check("rst_npcrdy", npc_ready, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_fault", inst_fault, 0);
    reset = 1'b0;

    // 1: zero-wait fetch, one stage per cycle
    do_ar(0, 32'h8000_0000);
    do_r(0, 32'h0010_0093, 2'b00);
    do_hold(0, 32'h0010_0093, 32'h8000_0000, 1'b0);
    do_npc(0, 32'h8000_0004);

    // 2: slow address and data channels
    do_ar(3, 32'h8000_0004);
    do_r(5, 32'h0020_8113, 2'b00);
    do_hold(0, 32'h0020_8113, 32'h8000_0004, 1'b0);
    do_npc(2, 32'h8000_0008);

    // 3: decode back-pressure with early npc_valid pulses
    do_ar(0, 32'h8000_0008);
    do_r(0, 32'h0031_8193, 2'b00);
    do_hold(10, 32'h0031_8193, 32'h8000_0008, 1'b0);
    do_npc(0, 32'h8000_0010);

    // 4: bus error response
    do_ar(0, 32'h8000_0010);
    do_r(1, 32'h1234_5678, 2'b10);
    do_hold(0, 32'h1234_5678, 32'h8000_0010, 1'b1);
    do_npc(0, 32'h8000_0002);

    // 5: misaligned next PC never reaches the bus
    check("mis_arvalid", arvalid, 0);
    check("mis_araddr", araddr, 32'h8000_0002);
    tick();
    check("mis_arvalid2", arvalid, 0);
    do_hold(0, 32'h0, 32'h8000_0002, 1'b1);
    do_npc(0, 32'h8000_0014);
    do_ar(0, 32'h8000_0014);

    // 6: reset in S_R, then in S_HOLD
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstR_arvalid", arvalid, 1);
    check("rstR_araddr", araddr, 32'h8000_0000);
    check("rstR_ivalid", inst_valid, 0);
    check("rstR_rready", rready, 0);
    do_ar(0, 32'h8000_0000);
    do_r(0, 32'h0040_0213, 2'b00);
    check("pre_rstH_valid", inst_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstH_arvalid", arvalid, 1);
    check("rstH_araddr", araddr, 32'h8000_0000);
    check("rstH_ivalid", inst_valid, 0);
    check("rstH_inst", inst, 0);
    check("rstH_npcrdy", npc_ready, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
